aes_dec: RTL and testbench

AES_DEC -- requirements
Module: aes_dec

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_inv_sbox.sv | 20 ++
 rtl/aes_sbox.sv | 21 ++
 rtl/aes_dec.sv | 144 ++++++++++++++
 tb/tb_aes_dec.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, constants and GF(2^8) helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: block/word/byte/round types, Nr, first/last rcon, FSM encoding,
//           xtime and a single-column InvMixColumns.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [7:0]   byte_t;
    typedef logic [3:0]   round_t;

    localparam int    Nr         = 10;
    localparam byte_t RCON_FIRST = 8'h01;
    localparam byte_t RCON_LAST  = 8'h36;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DECRYPT,
        ST_DONE
    } dec_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns; row r lives in bits [8r+7:8r].
    function automatic aes_word_t inv_mix_column(input aes_word_t col);
        byte_t     a, x2, x4, x8;
        byte_t     m9 [4];
        byte_t     mb [4];
        byte_t     md [4];
        byte_t     me [4];
        aes_word_t res;
        for (int r = 0; r < 4; r++) begin
            a     = col[8*r +: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a;
            mb[r] = x8 ^ x2 ^ a;
            md[r] = x8 ^ x4 ^ a;
            me[r] = x8 ^ x4 ^ x2;
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = me[r] ^ mb[2'(r + 1)] ^ md[2'(r + 2)] ^ m9[2'(r + 3)];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box lookup (combinational, 8-bit).
// Latency: 0 cycles.
// Backpressure: none.
// Ports: i_dat byte in, o_dat inverse-substituted byte out.
module aes_inv_sbox (
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat
);
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign o_dat = INV_SBOX[i_dat];
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box lookup (combinational, 8-bit).
// Latency: 0 cycles.
// Backpressure: none.
// Ports: i_dat byte in, o_dat substituted byte out.
module aes_sbox (
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat
);
    // Entry 0 sits in the most significant byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign o_dat = SBOX[i_dat];
endmodule

// File: rtl/aes_dec.sv
// AES-128 iterative decryptor: expands round key 10 on the fly, then runs
// 10 inverse rounds while walking the key schedule backwards.
// Latency: result valid 20 cycles after the accepting edge; ready only in IDLE.
// Backpressure: none on the output; data_valid_in is ignored while busy.
// Ports: data_valid_in/data_in/key_in request, ready_out idle indication,
//        res_dec_out live view of the state register, res_valid_out 1-cycle pulse.
module aes_dec
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         data_valid_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         ready_out,
    output logic [127:0] res_dec_out,
    output logic         res_valid_out
);

    dec_state_t r_fsm, w_fsm_nxt;
    round_t     r_cnt;
    byte_t      r_rcon;
    aes_block_t r_state;
    aes_block_t r_key;

    logic       w_last;
    aes_word_t  w_sub_src, w_sub_rot, w_sub_out, w_temp;
    aes_block_t w_fwd_key, w_inv_key, w_isr, w_isb, w_t, w_imc;

    assign w_last = (r_cnt == round_t'(Nr - 1));

    // The four S-boxes serve both key directions: forward steps feed w3,
    // backward steps feed the recovered w3 of the previous round key.
    assign w_sub_src = (r_fsm == ST_EXPAND) ? r_key[127:96]
                                            : (r_key[127:96] ^ r_key[95:64]);
    assign w_sub_rot = {w_sub_src[7:0], w_sub_src[31:8]};

    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (
            .i_dat (w_sub_rot[8*g +: 8]),
            .o_dat (w_sub_out[8*g +: 8])
        );
    end

    assign w_temp = w_sub_out ^ {24'h0, r_rcon};

    assign w_fwd_key = {
        r_key[127:96] ^ r_key[95:64] ^ r_key[63:32] ^ r_key[31:0] ^ w_temp,
        r_key[95:64] ^ r_key[63:32] ^ r_key[31:0] ^ w_temp,
        r_key[63:32] ^ r_key[31:0] ^ w_temp,
        r_key[31:0] ^ w_temp
    };

    assign w_inv_key = {
        r_key[127:96] ^ r_key[95:64],
        r_key[95:64] ^ r_key[63:32],
        r_key[63:32] ^ r_key[31:0],
        r_key[31:0] ^ w_temp
    };

    // InvShiftRows: row r of column c comes from column (c - r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_isr[32*c + 8*r +: 8] = r_state[32*((c - r + 4) % 4) + 8*r +: 8];
            aes_inv_sbox u_inv_sbox (
                .i_dat (w_isr[32*c + 8*r +: 8]),
                .o_dat (w_isb[32*c + 8*r +: 8])
            );
        end
        assign w_imc[32*c +: 32] = inv_mix_column(w_t[32*c +: 32]);
    end

    assign w_t = w_isb ^ w_inv_key;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE:    if (data_valid_in) w_fsm_nxt = ST_EXPAND;
            ST_EXPAND:  if (w_last)        w_fsm_nxt = ST_DECRYPT;
            ST_DECRYPT: if (w_last)        w_fsm_nxt = ST_DONE;
            ST_DONE:                       w_fsm_nxt = ST_IDLE;
            default:                       w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        ready_out     = (r_fsm == ST_IDLE);
        res_valid_out = (r_fsm == ST_DONE);
    end

    assign res_dec_out = r_state;

    // Datapath.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_rcon  <= RCON_FIRST;
            r_state <= '0;
            r_key   <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (data_valid_in) begin
                        r_state <= data_in;
                        r_key   <= key_in;
                        r_rcon  <= RCON_FIRST;
                        r_cnt   <= '0;
                    end
                end
                ST_EXPAND: begin
                    r_key <= w_fwd_key;
                    if (w_last) begin
                        // Keep rcon at its last forward value so the first
                        // backward step can undo round key 10 with it.
                        r_state <= r_state ^ w_fwd_key;
                        r_cnt   <= '0;
                    end else begin
                        r_rcon <= xtime(r_rcon);
                        r_cnt  <= r_cnt + round_t'(1);
                    end
                end
                ST_DECRYPT: begin
                    r_key   <= w_inv_key;
                    r_rcon  <= (r_rcon == 8'h1b) ? 8'h80 : (r_rcon >> 1);
                    r_state <= w_last ? w_t : w_imc;
                    r_cnt   <= w_last ? '0 : r_cnt + round_t'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec.sv
// Directed bench for aes_dec: known-answer vectors in a table, continuous
// request handling, and mid-block reset aborts.
// Ports: none (top-level bench).
module tb_aes_dec;

    logic         clk = 1'b0;
    logic         resetn;
    logic         data_valid_in;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         ready_out;
    logic [127:0] res_dec_out;
    logic         res_valid_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_dec dut (
        .clk           (clk),
        .resetn        (resetn),
        .data_valid_in (data_valid_in),
        .data_in       (data_in),
        .key_in        (key_in),
        .ready_out     (ready_out),
        .res_dec_out   (res_dec_out),
        .res_valid_out (res_valid_out)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one block while in IDLE, follow it to DONE and one cycle past.
    // With hold_valid set, data_valid_in stays high and inputs keep changing.
    task automatic run_vec(input vec_t v, input string tag, input bit hold_valid);
        int n;
        bit seen;
        data_valid_in = 1'b1;
        data_in       = v.ct;
        key_in        = v.key;
        @(posedge clk); #1;
        chk({tag, " busy after accept"}, 128'(ready_out), 128'd0);
        if (!hold_valid) data_valid_in = 1'b0;
        data_in = rand128();
        key_in  = rand128();
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            data_in = rand128();
            key_in  = rand128();
            if (n == 10) chk({tag, " rcon first decrypt"}, 128'(dut.r_rcon), 128'h36);
            if (n == 19) chk({tag, " rcon last decrypt"}, 128'(dut.r_rcon), 128'h01);
            if (res_valid_out) seen = 1'b1;
        end
        chk({tag, " latency"}, 128'(n), 128'd20);
        chk({tag, " plaintext"}, res_dec_out, v.pt);
        chk({tag, " key restored"}, dut.r_key, v.key);
        chk({tag, " ready low in done"}, 128'(ready_out), 128'd0);
        @(posedge clk); #1;
        chk({tag, " single pulse"}, 128'(res_valid_out), 128'd0);
        chk({tag, " ready in idle"}, 128'(ready_out), 128'd1);
        chk({tag, " result held"}, res_dec_out, v.pt);
    endtask

    // Start a block and pull resetn low at edge k+m.
    task automatic abort_at(input vec_t v, input int m, input string tag);
        int pulses;
        data_valid_in = 1'b1;
        data_in       = v.ct;
        key_in        = v.key;
        @(posedge clk); #1;
        data_valid_in = 1'b0;
        repeat (m - 1) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk({tag, " ready"}, 128'(ready_out), 128'd1);
        chk({tag, " output cleared"}, res_dec_out, 128'd0);
        chk({tag, " no valid"}, 128'(res_valid_out), 128'd0);
        chk({tag, " rcon reset"}, 128'(dut.r_rcon), 128'h01);
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (res_valid_out) pulses++;
        end
        chk({tag, " no late pulse"}, 128'(pulses), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // FIPS-197 C.1, App. B, and two all-zero-key known answers.
        vecs[0] = '{key: 128'h0f0e0d0c0b0a09080706050403020100,
                    ct:  128'h5ac5b47080b7cdd830047b6ad8e0c469,
                    pt:  128'hffeeddccbbaa99887766554433221100};
        vecs[1] = '{key: 128'h3c4fcf098815f7aba6d2ae2816157e2b,
                    ct:  128'h320b6a19978511dcfb09dc021d842539,
                    pt:  128'h340737e0a29831318d305a88a8f64332};
        vecs[2] = '{key: 128'h0,
                    ct:  128'h2e2b34ca59fa4c883b2c8aefd44be966,
                    pt:  128'h0};
        vecs[3] = '{key: 128'h0,
                    ct:  128'h5e7f53cec97c565a59926d963e763603,
                    pt:  128'he673f208fbc35dcdba27c63cec8144f3};

        resetn        = 1'b0;
        data_valid_in = 1'b0;
        data_in       = '0;
        key_in        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 128'(ready_out), 128'd1);
        chk("reset valid", 128'(res_valid_out), 128'd0);
        chk("reset output", res_dec_out, 128'd0);
        chk("reset rcon", 128'(dut.r_rcon), 128'h01);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Request held high across two blocks with garbage between them.
        run_vec(vecs[0], "hold A", 1'b1);
        run_vec(vecs[1], "hold B", 1'b1);
        data_valid_in = 1'b0;
        @(posedge clk); #1;
        chk("hold idle after drop", 128'(ready_out), 128'd1);

        abort_at(vecs[1], 5, "abort k+5");
        abort_at(vecs[0], 15, "abort k+15");
        run_vec(vecs[0], "after abort", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
